// File: rtl/usb_rx_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usb_rx_pkg
// Description : Shared types and USB timing constants for the RX timer. The
//               constants are the same values the TX side uses.
// Revision    : 1.0 - initial release
// ============================================================================
package usb_rx_pkg;

  // Two-state timer controller: waiting for the first line edge, or running
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } rx_tmr_state_t;

  localparam int USB_CLKS_PER_BIT  = 8;
  localparam int USB_BITS_PER_BYTE = 8;

endpackage
`default_nettype wire

// File: rtl/sync_flex_counter.sv
`default_nettype none
// ============================================================================
// Module      : sync_flex_counter
// Description : Up-counter with a programmable wrap value. A synchronous clear
//               has priority over the count enable. The count goes from 0 to
//               i_rollover_val and then wraps to 0.
// Ports       : clk             - clock, rising edge
//               rst             - synchronous reset, active-high
//               i_clear         - synchronous clear to 0, priority over enable
//               i_enable        - advance the count by one
//               i_rollover_val  - last value before wrapping to 0
//               o_count         - current count
//               o_rollover_flag - count currently equals i_rollover_val
// Revision    : 1.0 - initial release
// ============================================================================
module sync_flex_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_rollover_val,
  output logic [WIDTH-1:0] o_count,
  output logic             o_rollover_flag
);

  logic [WIDTH-1:0] r_count;
  logic             w_at_rollover;

  assign w_at_rollover = (r_count == i_rollover_val);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      if (w_at_rollover) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign o_count         = r_count;
  assign o_rollover_flag = w_at_rollover;

endmodule
`default_nettype wire

// File: rtl/usb_rx_timer.sv
`default_nettype none
// ============================================================================
// Module      : usb_rx_timer
// Description : Receive-side bit/byte timing. Recovers the bit phase from line
//               transitions, pulses o_shift_enable at the sample point of
//               each bit, counts non-stuffed bits and pulses o_byte_received
//               once per byte.
// Ports       : clk             - system clock, rising edge
//               rst             - synchronous reset, active-high
//               i_rcving        - packet reception in progress
//               i_d_edge        - 1-cycle pulse, line transition seen
//               i_stuff_skip    - sampled bit is a stuffed bit (with shift)
//               o_shift_enable  - 1-cycle pulse at the bit sample point
//               o_byte_received - 1-cycle pulse, a full byte was counted
//               o_bit_count     - counted bits in the current byte
//               o_timer_active  - timer is in the RUN state
// Revision    : 1.0 - initial release
// ============================================================================
module usb_rx_timer
  import usb_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT  = USB_CLKS_PER_BIT,
  parameter int SAMPLE_POINT  = 3,
  parameter int BITS_PER_BYTE = USB_BITS_PER_BYTE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rcving,
  input  logic       i_d_edge,
  input  logic       i_stuff_skip,
  output logic       o_shift_enable,
  output logic       o_byte_received,
  output logic [3:0] o_bit_count,
  output logic       o_timer_active
);

  localparam int PHASE_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [PHASE_W-1:0] c_PHASE_MAX    = PHASE_W'(CLKS_PER_BIT - 1);
  localparam logic [PHASE_W-1:0] c_PHASE_SAMPLE = PHASE_W'(SAMPLE_POINT);
  localparam logic [3:0]         c_BIT_MAX      = 4'(BITS_PER_BYTE - 1);

  rx_tmr_state_t      r_state;
  logic               r_byte_received;

  logic               w_run;
  logic [PHASE_W-1:0] w_phase;
  logic               w_phase_clear;
  logic               w_phase_wrap_unused;
  logic               w_shift_enable;
  logic               w_bit_enable;
  logic               w_bit_clear;
  logic [3:0]         w_bit_count;
  logic               w_bit_last;

  assign w_run = (r_state == RUN);

  // An edge resyncs the phase to 0; dropping rcving parks it at 0. While in
  // IDLE the counter is held, so the edge that starts a packet leaves it at 0.
  // An edge at the last phase lands on 0 exactly like a normal wrap.
  assign w_phase_clear = i_d_edge | ~i_rcving;

  sync_flex_counter #(
    .WIDTH (PHASE_W)
  ) u_phase_cnt (
    .clk             (clk),
    .rst             (rst),
    .i_clear         (w_phase_clear),
    .i_enable        (w_run),
    .i_rollover_val  (c_PHASE_MAX),
    .o_count         (w_phase),
    .o_rollover_flag (w_phase_wrap_unused)
  );

  // Decoded purely from registers, so an edge arriving in the sample cycle
  // cannot suppress that cycle's pulse.
  assign w_shift_enable = w_run && (w_phase == c_PHASE_SAMPLE);

  // Stuffed bits are not counted; stuff_skip only matters at the sample point.
  assign w_bit_enable = w_shift_enable & ~i_stuff_skip;
  // Leaving reception discards the partial byte, even over a pending shift.
  assign w_bit_clear  = ~i_rcving;

  sync_flex_counter #(
    .WIDTH (4)
  ) u_bit_cnt (
    .clk             (clk),
    .rst             (rst),
    .i_clear         (w_bit_clear),
    .i_enable        (w_bit_enable),
    .i_rollover_val  (c_BIT_MAX),
    .o_count         (w_bit_count),
    .o_rollover_flag (w_bit_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_byte_received <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_rcving && i_d_edge) begin
            r_state <= RUN;
          end
        end
        RUN: begin
          if (!i_rcving) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
      // Byte completes when the last counted bit is sampled; a completion
      // in the same cycle reception ends is dropped with the partial byte.
      r_byte_received <= w_bit_enable & w_bit_last & i_rcving;
    end
  end

  assign o_shift_enable  = w_shift_enable;
  assign o_byte_received = r_byte_received;
  assign o_bit_count     = w_bit_count;
  assign o_timer_active  = w_run;

endmodule
`default_nettype wire
